// File: rtl/bcd_counter_n_if.sv
// bcd_counter_n_if: control inputs and count outputs of one bcd_counter_n stage.
// Master drives enable/direction/load; slave is the counter itself.
interface bcd_counter_n_if #(
    parameter int DIGITS = 2
);
    logic                  iEn;
    logic                  iUp;
    logic                  iLoad;
    logic [4*DIGITS-1:0]   iLoadValue;
    logic [4*DIGITS-1:0]   oCount;
    logic                  oTc;
    logic                  oWrap;
    logic                  oLoadErr;

    modport master (
        output iEn, iUp, iLoad, iLoadValue,
        input  oCount, oTc, oWrap, oLoadErr
    );

    modport slave (
        input  iEn, iUp, iLoad, iLoadValue,
        output oCount, oTc, oWrap, oLoadErr
    );
endinterface

// File: rtl/bcd_counter_n.sv
// bcd_counter_n: N-digit BCD up/down counter with checked parallel load and cascade terminal count.
// Latency: oCount/oWrap/oLoadErr one cycle after the sampling edge; oTc is combinational.
// Backpressure: none, one step per enabled cycle. BCD_SATURATE_EN selects saturation instead of wrap.
module bcd_counter_n #(
    parameter int                  DIGITS    = 2,
    parameter logic [4*DIGITS-1:0] RST_VALUE = '0
) (
    input  logic           iClk,
    input  logic           iRst,
    bcd_counter_n_if.slave bus
);
    logic [4*DIGITS-1:0] count;
    logic [4*DIGITS-1:0] stepped;
    logic                wrap;
    logic                load_err;
    logic                all_nine;
    logic                all_zero;
    logic                load_ok;
    logic                boundary;
    logic                chain;
    logic [3:0]          digit;

    always_comb begin
        all_nine = 1'b1;
        all_zero = 1'b1;
        load_ok  = 1'b1;
        for (int k = 0; k < DIGITS; k++) begin
            all_nine = all_nine & (count[4*k +: 4] == 4'd9);
            all_zero = all_zero & (count[4*k +: 4] == 4'd0);
            load_ok  = load_ok & (bus.iLoadValue[4*k +: 4] <= 4'd9);
        end
    end

    // Carry/borrow ripples digit by digit; each digit is modulo 10, never binary.
    always_comb begin
        chain   = 1'b1;
        digit   = 4'd0;
        stepped = count;
        for (int k = 0; k < DIGITS; k++) begin
            digit = count[4*k +: 4];
            if (chain) begin
                if (bus.iUp) begin
                    if (digit == 4'd9) begin
                        stepped[4*k +: 4] = 4'd0;
                    end else begin
                        stepped[4*k +: 4] = digit + 4'd1;
                        chain = 1'b0;
                    end
                end else begin
                    if (digit == 4'd0) begin
                        stepped[4*k +: 4] = 4'd9;
                    end else begin
                        stepped[4*k +: 4] = digit - 4'd1;
                        chain = 1'b0;
                    end
                end
            end
        end
    end

    assign boundary = bus.iUp ? all_nine : all_zero;

    always_ff @(posedge iClk) begin
        if (iRst) begin
            count    <= RST_VALUE;
            wrap     <= 1'b0;
            load_err <= 1'b0;
        end else begin
            wrap     <= 1'b0;
            load_err <= 1'b0;
            if (bus.iLoad) begin
                if (load_ok) begin
                    count <= bus.iLoadValue;
                end else begin
                    load_err <= 1'b1;
                end
            end else if (bus.iEn) begin
                if (boundary) begin
                    wrap <= 1'b1;
                end
`ifdef BCD_SATURATE_EN
                if (!boundary) begin
                    count <= stepped;
                end
`else
                count <= stepped;
`endif
            end
        end
    end

    assign bus.oCount   = count;
    assign bus.oTc      = bus.iEn & boundary;
    assign bus.oWrap    = wrap;
    assign bus.oLoadErr = load_err;
endmodule

// File: tb/tb_bcd_counter_n.sv
// Bench for bcd_counter_n: a 2-digit counter, a cascade of two 1-digit stages and a 4-digit counter,
// checked against an integer reference model through an expected-result queue.
module tb_bcd_counter_n;
    typedef struct packed {
        logic [15:0] count;
        logic        wrap;
        logic        load_err;
        logic        tc;
    } exp_t;

    logic clk = 1'b0;
    logic rst2, rstc, rst4;
    always #5 clk = ~clk;

    bcd_counter_n_if #(.DIGITS(2)) b2 ();
    bcd_counter_n_if #(.DIGITS(1)) bc_lo ();
    bcd_counter_n_if #(.DIGITS(1)) bc_hi ();
    bcd_counter_n_if #(.DIGITS(4)) b4 ();

    bcd_counter_n #(.DIGITS(2), .RST_VALUE(8'h00)) u2 (
        .iClk(clk), .iRst(rst2), .bus(b2.slave));
    bcd_counter_n #(.DIGITS(1), .RST_VALUE(4'h0)) u_lo (
        .iClk(clk), .iRst(rstc), .bus(bc_lo.slave));
    bcd_counter_n #(.DIGITS(1), .RST_VALUE(4'h0)) u_hi (
        .iClk(clk), .iRst(rstc), .bus(bc_hi.slave));
    bcd_counter_n #(.DIGITS(4), .RST_VALUE(16'h9998)) u4 (
        .iClk(clk), .iRst(rst4), .bus(b4.slave));

    assign bc_hi.iEn = bc_lo.oTc;
    assign bc_hi.iUp = bc_lo.iUp;

    exp_t        sb[$];
    exp_t        e;
    int          m2, mc, m4;
    int          checks = 0;
    int          passed = 0;
    logic [15:0] count_obs;
    logic        wrap_obs, lerr_obs, tc_obs;

    function automatic logic [15:0] bcd_enc(input int v, input int digits);
        logic [15:0] r;
        int          t;
        r = '0;
        t = v;
        for (int k = 0; k < digits; k++) begin
            r[4*k +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    function automatic bit bcd_ok(input logic [15:0] lv, input int digits);
        bit ok;
        ok = 1'b1;
        for (int k = 0; k < digits; k++) if (lv[4*k +: 4] > 4'd9) ok = 1'b0;
        return ok;
    endfunction

    function automatic int bcd_dec(input logic [15:0] lv, input int digits);
        int v;
        v = 0;
        for (int k = digits - 1; k >= 0; k--) v = v * 10 + int'(lv[4*k +: 4]);
        return v;
    endfunction

    // Drives one cycle on the selected counter (0: 2-digit, 1: cascade, 2: 4-digit),
    // pushes the model's expectation and captures the DUT outputs after the edge.
    task automatic drive(input int sel, input bit r, input bit ld, input bit en,
                         input bit up, input logic [15:0] lv);
        int   digits, modv, mv, rv;
        exp_t x;
        digits = (sel == 2) ? 4 : 2;
        modv   = (sel == 2) ? 10000 : 100;
        rv     = (sel == 2) ? 9998 : 0;
        mv     = (sel == 0) ? m2 : (sel == 1) ? mc : m4;

        rst2 = (sel == 0) && r;
        rstc = (sel == 1) && r;
        rst4 = (sel == 2) && r;
        b2.iLoad = (sel == 0) && ld;
        b2.iEn = (sel == 0) && en;
        b2.iUp = up;
        b2.iLoadValue = lv[7:0];
        bc_lo.iLoad = (sel == 1) && ld;
        bc_hi.iLoad = (sel == 1) && ld;
        bc_lo.iEn = (sel == 1) && en;
        bc_lo.iUp = up;
        bc_lo.iLoadValue = lv[3:0];
        bc_hi.iLoadValue = lv[7:4];
        b4.iLoad = (sel == 2) && ld;
        b4.iEn = (sel == 2) && en;
        b4.iUp = up;
        b4.iLoadValue = lv;
        #1;
        tc_obs = (sel == 0) ? b2.oTc : (sel == 1) ? bc_hi.oTc : b4.oTc;

        x.tc       = en && (up ? (mv == modv - 1) : (mv == 0));
        x.wrap     = 1'b0;
        x.load_err = 1'b0;
        if (r) begin
            mv = rv;
        end else if (ld) begin
            if (bcd_ok(lv, digits)) mv = bcd_dec(lv, digits);
            else x.load_err = 1'b1;
        end else if (en) begin
            if (up && mv == modv - 1) begin
                x.wrap = 1'b1;
`ifndef BCD_SATURATE_EN
                mv = 0;
`endif
            end else if (!up && mv == 0) begin
                x.wrap = 1'b1;
`ifndef BCD_SATURATE_EN
                mv = modv - 1;
`endif
            end else begin
                mv = up ? mv + 1 : mv - 1;
            end
        end
        x.count = bcd_enc(mv, digits);
        sb.push_back(x);
        if (sel == 0) m2 = mv;
        else if (sel == 1) mc = mv;
        else m4 = mv;

        @(posedge clk);
        #1;
        case (sel)
            0: begin
                count_obs = {8'h00, b2.oCount};
                wrap_obs  = b2.oWrap;
                lerr_obs  = b2.oLoadErr;
            end
            1: begin
                count_obs = {8'h00, bc_hi.oCount, bc_lo.oCount};
                wrap_obs  = bc_hi.oWrap;
                lerr_obs  = bc_lo.oLoadErr | bc_hi.oLoadErr;
            end
            default: begin
                count_obs = b4.oCount;
                wrap_obs  = b4.oWrap;
                lerr_obs  = b4.oLoadErr;
            end
        endcase
    endtask

    task automatic test_reset();
        for (int s = 0; s < 3; s++) begin
            drive(s, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0000);
            e = sb.pop_front();
            checks++;
            if (count_obs !== e.count || wrap_obs !== e.wrap || lerr_obs !== e.load_err || tc_obs !== e.tc)
                $display("FAIL reset sel=%0d: got count=%h wrap=%b err=%b tc=%b, want count=%h wrap=%b err=%b tc=%b",
                         s, count_obs, wrap_obs, lerr_obs, tc_obs, e.count, e.wrap, e.load_err, e.tc);
            else passed++;
        end
    endtask

    task automatic test_up_count();
        for (int i = 0; i < 100; i++) begin
            drive(0, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0000);
            e = sb.pop_front();
            checks++;
            if (count_obs !== e.count || wrap_obs !== e.wrap || lerr_obs !== e.load_err || tc_obs !== e.tc)
                $display("FAIL up_count step %0d: got count=%h wrap=%b err=%b tc=%b, want count=%h wrap=%b err=%b tc=%b",
                         i, count_obs, wrap_obs, lerr_obs, tc_obs, e.count, e.wrap, e.load_err, e.tc);
            else passed++;
        end
    endtask

    task automatic test_down_count();
        for (int i = 0; i < 14; i++) begin
            drive(0, 1'b0, i == 0, 1'b1, 1'b0, 16'h0010);
            e = sb.pop_front();
            checks++;
            if (count_obs !== e.count || wrap_obs !== e.wrap || lerr_obs !== e.load_err || tc_obs !== e.tc)
                $display("FAIL down_count step %0d: got count=%h wrap=%b err=%b tc=%b, want count=%h wrap=%b err=%b tc=%b",
                         i, count_obs, wrap_obs, lerr_obs, tc_obs, e.count, e.wrap, e.load_err, e.tc);
            else passed++;
        end
    endtask

    task automatic test_load_validation();
        logic [15:0] vals [5] = '{16'h0047, 16'h004A, 16'h00F0, 16'h0000, 16'h0090};
        bit          lds  [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        bit          ens  [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        for (int i = 0; i < 5; i++) begin
            drive(0, 1'b0, lds[i], ens[i], 1'b1, vals[i]);
            e = sb.pop_front();
            checks++;
            if (count_obs !== e.count || wrap_obs !== e.wrap || lerr_obs !== e.load_err || tc_obs !== e.tc)
                $display("FAIL load_validation step %0d: got count=%h wrap=%b err=%b tc=%b, want count=%h wrap=%b err=%b tc=%b",
                         i, count_obs, wrap_obs, lerr_obs, tc_obs, e.count, e.wrap, e.load_err, e.tc);
            else passed++;
        end
    endtask

    task automatic test_priority();
        bit          rs  [8] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        bit          lds [8] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        bit          ens [8] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        logic [15:0] lvs [8] = '{16'h0012, 16'h0055, 16'h0055, 16'h0099, 16'h0000,
                                 16'h0000, 16'h00AB, 16'h0000};
        for (int i = 0; i < 8; i++) begin
            drive(0, rs[i], lds[i], ens[i], 1'b1, lvs[i]);
            e = sb.pop_front();
            checks++;
            if (count_obs !== e.count || wrap_obs !== e.wrap || lerr_obs !== e.load_err || tc_obs !== e.tc)
                $display("FAIL priority step %0d: got count=%h wrap=%b err=%b tc=%b, want count=%h wrap=%b err=%b tc=%b",
                         i, count_obs, wrap_obs, lerr_obs, tc_obs, e.count, e.wrap, e.load_err, e.tc);
            else passed++;
        end
    endtask

    task automatic test_random();
        bit          r, ld, en, up;
        logic [15:0] lv;
        for (int i = 0; i < 200; i++) begin
            r  = ($urandom_range(0, 19) == 0);
            ld = ($urandom_range(0, 4) == 0);
            en = ($urandom_range(0, 3) != 0);
            up = 1'($urandom_range(0, 1));
            lv = 16'($urandom_range(0, 255));
            drive(0, r, ld, en, up, lv);
            e = sb.pop_front();
            checks++;
            if (count_obs !== e.count || wrap_obs !== e.wrap || lerr_obs !== e.load_err || tc_obs !== e.tc)
                $display("FAIL random step %0d: got count=%h wrap=%b err=%b tc=%b, want count=%h wrap=%b err=%b tc=%b",
                         i, count_obs, wrap_obs, lerr_obs, tc_obs, e.count, e.wrap, e.load_err, e.tc);
            else passed++;
        end
    endtask

`ifndef BCD_SATURATE_EN
    task automatic test_cascade();
        for (int i = 0; i < 201; i++) begin
            drive(1, i == 0, 1'b0, i != 0, i <= 100, 16'h0000);
            e = sb.pop_front();
            checks++;
            if (count_obs !== e.count || wrap_obs !== e.wrap || lerr_obs !== e.load_err || tc_obs !== e.tc)
                $display("FAIL cascade step %0d: got count=%h wrap=%b err=%b tc=%b, want count=%h wrap=%b err=%b tc=%b",
                         i, count_obs, wrap_obs, lerr_obs, tc_obs, e.count, e.wrap, e.load_err, e.tc);
            else passed++;
        end
    endtask
`endif

    task automatic test_width_sweep();
        for (int i = 0; i < 14; i++) begin
            drive(2, i == 0, 1'b0, (i >= 1 && i <= 3), 1'b1, 16'h0000);
            e = sb.pop_front();
            checks++;
            if (count_obs !== e.count || wrap_obs !== e.wrap || lerr_obs !== e.load_err || tc_obs !== e.tc)
                $display("FAIL width_sweep step %0d: got count=%h wrap=%b err=%b tc=%b, want count=%h wrap=%b err=%b tc=%b",
                         i, count_obs, wrap_obs, lerr_obs, tc_obs, e.count, e.wrap, e.load_err, e.tc);
            else passed++;
        end
    endtask

    initial begin
        rst2 = 1'b0;
        rstc = 1'b0;
        rst4 = 1'b0;
        b2.iEn = 1'b0;
        b2.iUp = 1'b1;
        b2.iLoad = 1'b0;
        b2.iLoadValue = '0;
        bc_lo.iEn = 1'b0;
        bc_lo.iUp = 1'b1;
        bc_lo.iLoad = 1'b0;
        bc_lo.iLoadValue = '0;
        bc_hi.iLoad = 1'b0;
        bc_hi.iLoadValue = '0;
        b4.iEn = 1'b0;
        b4.iUp = 1'b1;
        b4.iLoad = 1'b0;
        b4.iLoadValue = '0;
        m2 = 0;
        mc = 0;
        m4 = 0;
        #2;
        test_reset();
        test_up_count();
        test_down_count();
        test_load_validation();
        test_priority();
        test_random();
`ifndef BCD_SATURATE_EN
        test_cascade();
`endif
        test_width_sweep();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
